// File: rtl/fetch_redirect.sv
// fetch_redirect: PC register, instruction-ROM addressing, IF/ID stage register,
// and EX-stage branch resolution with redirect/squash of wrong-path fetches.
module fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk_cpu,
    input  logic        rst_cpu,
    input  logic [31:0] irom_inst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [2:0]  ex_branch,
    input  logic        ex_zero,
    input  logic        ex_lt,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_alu_res,
    output logic [31:0] irom_addr,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        flush_idex,
    output logic [31:0] taken_cnt
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] CNT_STEP = XLEN'(1);
    localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BGE  = 3'b011,
        BR_BLT  = 3'b100,
        BR_JAL  = 3'b101,
        BR_JALR = 3'b110,
        BR_RSVD = 3'b111
    } branch_e;

    branch_e         br_code;
    logic            taken;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_q;

    assign br_code = branch_e'(ex_branch);

    // Taken decision from the branch code and comparison flags; bubbles never redirect
    always_comb begin
        taken = 1'b0;
        if (ex_valid) begin
            case (br_code)
                BR_BEQ:  taken = ex_zero;
                BR_BNE:  taken = ~ex_zero;
                BR_BGE:  taken = ~ex_lt;
                BR_BLT:  taken = ex_lt;
                BR_JAL:  taken = 1'b1;
                BR_JALR: taken = 1'b1;
                BR_NONE: taken = 1'b0;
                BR_RSVD: taken = 1'b0;
                default: taken = 1'b0;
            endcase
        end
    end

    // Redirect target: jalr clears bit 0 of rs1+imm, everything else is pc-relative
    always_comb begin
        target = ex_pc + ex_imm;
        if (br_code == BR_JALR) begin
            target = ex_alu_res & JALR_MASK;
        end
    end

    assign redirect   = taken;
    assign flush_idex = redirect;
    assign irom_addr  = pc_q;

    // PC register: reset > redirect > stall > sequential fetch
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= target;
        end else if (!stall) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    // IF/ID stage register; a redirect squashes the fetched word even when stalled
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            ifid_inst  <= NOP;
            ifid_pc    <= '0;
            ifid_pc4   <= PC_STEP;
            ifid_valid <= 1'b0;
        end else if (redirect) begin
            ifid_inst  <= NOP;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_inst  <= irom_inst;
            ifid_pc    <= pc_q;
            ifid_pc4   <= pc_q + PC_STEP;
            ifid_valid <= 1'b1;
        end
    end

    // Redirect counter, wraps naturally at 2^32
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            taken_cnt <= '0;
        end else if (redirect) begin
            taken_cnt <= taken_cnt + CNT_STEP;
        end
    end

endmodule
